// File: rtl/mem_stage_pipe_pkg.sv
// Shared pipeline-register package.
// Holds the skid-mode encodings, the default control/data widths for the
// EX/MEM and MEM/WB stage registers, and the positions of the control bits
// inside the control field.
package mem_stage_pipe_pkg;

   // Values for the SKID_EN parameter.
   localparam int SKID_OFF = 0;   // single entry, combinational in_ready
   localparam int SKID_ON  = 1;   // main + skid entry, registered in_ready

   // EX/MEM register: RegWrite, MemtoReg, MemWrite;
   // ALUResult 32 + WriteData 32 + rd 5 + rs2 5.
   localparam int EXMEM_CTRL_W = 3;
   localparam int EXMEM_DATA_W = 74;

   // MEM/WB register: RegWrite, MemtoReg;
   // ReadData 32 + ALUResult 32 + rd 5.
   localparam int MEMWB_CTRL_W = 2;
   localparam int MEMWB_DATA_W = 69;

   // Control-bit positions within the control field.
   localparam int REGWRITE_BIT = 0;
   localparam int MEMTOREG_BIT = 1;
   localparam int MEMWRITE_BIT = 2;

endpackage

// File: rtl/mem_stage_pipe_entry_reg.sv
// pipe_entry_reg: one valid + ctrl + data holding register.
// Ports:
//   clk, rst      clock and synchronous active-high reset (clears everything)
//   clr           invalidate the entry (ctrl zeroed, data held)
//   load          capture valid_in/ctrl_in/data_in
//   valid_in, ctrl_in, data_in   entry presented for loading
//   valid, ctrl, data            held entry
// Priority: rst > clr > load > hold. Loading a bubble (valid_in=0) zeroes
// ctrl and keeps the previous data, so bubbles never carry live control.
module pipe_entry_reg
   import mem_stage_pipe_pkg::*;
#(
   parameter int CTRL_W = EXMEM_CTRL_W,
   parameter int DATA_W = EXMEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load,
   input  logic              valid_in,
   input  logic [CTRL_W-1:0] ctrl_in,
   input  logic [DATA_W-1:0] data_in,
   output logic              valid,
   output logic [CTRL_W-1:0] ctrl,
   output logic [DATA_W-1:0] data
);

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
   logic [DATA_W-1:0] data_q,  data_d;

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      if (clr) begin
         valid_d = 1'b0;
         ctrl_d  = '0;
      end else if (load) begin
         valid_d = valid_in;
         ctrl_d  = valid_in ? ctrl_in : '0;
         if (valid_in) begin
            data_d = data_in;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign ctrl  = ctrl_q;
   assign data  = data_q;

endmodule

// File: rtl/mem_stage_pipe.sv
// mem_stage_pipe: generic pipeline-stage register with valid/ready handshake,
// optional skid entry, synchronous flush, bubble ctrl-zeroing and a
// saturating stall counter.
// Ports:
//   CLK, RESET            clock, synchronous active-high reset
//   Stall                 global hold: no accept, no emit, state frozen
//   Flush                 drop every held entry on the next edge
//   in_valid/in_ready     upstream handshake; in_ctrl/in_data payload
//   out_valid/out_ready   downstream handshake; out_ctrl/out_data payload
//   stall_cnt             saturating count of cycles holding a valid entry
// Handshake: a transfer happens on an edge where valid and ready are both
// high; go = out_ready & ~Stall, out_fire = out_valid & go,
// in_fire = in_valid & in_ready. Entries leave in arrival order.
module mem_stage_pipe
   import mem_stage_pipe_pkg::*;
#(
   parameter int CTRL_W  = EXMEM_CTRL_W,
   parameter int DATA_W  = EXMEM_DATA_W,
   parameter int SKID_EN = SKID_ON,
   parameter int CNT_W   = 16
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              Stall,
   input  logic              Flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   logic              go, out_fire, in_fire;

   logic              main_valid;
   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;
   logic              main_load, main_clr, main_vin;
   logic [CTRL_W-1:0] main_cin;
   logic [DATA_W-1:0] main_din;

   logic              skid_valid;
   logic [CTRL_W-1:0] skid_ctrl;
   logic [DATA_W-1:0] skid_data;

   logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

   assign go       = out_ready & ~Stall;
   assign out_fire = main_valid & go;
   assign in_fire  = in_valid & in_ready;

   // Main entry refills whenever it empties or emits: skid first (it is the
   // older entry), then the incoming entry, otherwise it becomes a bubble.
   always_comb begin
      main_load = 1'b0;
      main_clr  = 1'b0;
      main_vin  = 1'b0;
      main_cin  = '0;
      main_din  = in_data;
      if (Flush) begin
         main_clr = 1'b1;
      end else if (!Stall && (out_fire || !main_valid)) begin
         main_load = 1'b1;
         if (skid_valid) begin
            main_vin = 1'b1;
            main_cin = skid_ctrl;
            main_din = skid_data;
         end else if (in_fire) begin
            main_vin = 1'b1;
            main_cin = in_ctrl;
         end
      end
   end

   pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
      .clk      (CLK),
      .rst      (RESET),
      .clr      (main_clr),
      .load     (main_load),
      .valid_in (main_vin),
      .ctrl_in  (main_cin),
      .data_in  (main_din),
      .valid    (main_valid),
      .ctrl     (main_ctrl),
      .data     (main_data)
   );

   generate
      if (SKID_EN == SKID_ON) begin : g_skid
         logic skid_load, skid_clr;

         // in_ready depends only on registered state, so out_ready has no
         // combinational path to in_ready.
         assign in_ready = ~skid_valid & ~Stall;

         // Skid catches an accepted entry that main cannot take this edge,
         // and empties when main pulls it on the next emit.
         always_comb begin
            skid_load = 1'b0;
            skid_clr  = 1'b0;
            if (Flush) begin
               skid_clr = 1'b1;
            end else if (out_fire && skid_valid) begin
               skid_clr = 1'b1;
            end else if (in_fire && main_valid && !out_fire) begin
               skid_load = 1'b1;
            end
         end

         pipe_entry_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
            .clk      (CLK),
            .rst      (RESET),
            .clr      (skid_clr),
            .load     (skid_load),
            .valid_in (1'b1),
            .ctrl_in  (in_ctrl),
            .data_in  (in_data),
            .valid    (skid_valid),
            .ctrl     (skid_ctrl),
            .data     (skid_data)
         );
      end else begin : g_no_skid
         assign skid_valid = 1'b0;
         assign skid_ctrl  = '0;
         assign skid_data  = '0;
         assign in_ready   = ~Stall & (~main_valid | out_ready);
      end
   endgenerate

   // Counts every cycle a valid entry is held back; sticks at all-ones.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (main_valid && !go && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign out_valid = main_valid;
   assign out_ctrl  = main_valid ? main_ctrl : '0;
   assign out_data  = main_data;
   assign stall_cnt = stall_cnt_q;

endmodule
